rgb_sequence_controller: RTL and testbench
==========================================

Name: rgb_sequence_controller

Overview:
Sequencer that produces the 8-bit R/G/B duty words consumed by the PWM output stage. It steps or fades through the team's fixed 7-colour palette. Operating mode comes from sw[1:0], and a manual step input is available. It replaces the free-running colour cycler and drops into the same place in the design, with identical output port names.

Parameters:
TICK_DIV, 195313, clk cycles per internal tick (50 MHz / 195313 ≈ 256 ticks/s). Must be ≥ 2.
HOLD_TICKS, 256, ticks a colour is held before auto-advance. Must be ≥ 1.

Ports:
clk  in  1  system clock
rst  in  1  reset, asynchronous, active-high
sw  in  2  mode: 00 freeze, 01 auto-jump, 10 auto-fade, 11 manual
step  in  1  manual advance request, level; the rising edge is detected internally
R_time_out  out  8  red duty word
G_time_out  out  8  green duty word
B_time_out  out  8  blue duty word
color_idx  out  3  current target palette index
fading  out  1  high while outputs are moving toward the target

Behaviour:
- One clock; reset is asynchronous and active-high.
- Reset values: all duty outputs 0, color_idx 0, fading 0, state S_IDLE, tick prescaler 0, hold counter 0, step edge register 0.
- All outputs are registered.
- Palette, indices 0..7 as (R,G,B):
  - 0 off (0,0,0)
  - 1 red (255,0,0)
  - 2 orange (255,97,0)
  - 3 yellow (255,255,0)
  - 4 green (0,255,0)
  - 5 blue (0,0,255)
  - 6 pinying (8,46,84)
  - 7 purple (160,32,240)
- Advance order is 1→2→…→7→1. Index 0 is only reachable through reset.
- tick: one-cycle pulse, asserted when the prescaler equals TICK_DIV-1; the prescaler then wraps to 0.
  - The prescaler runs in every mode except 00, where it holds its value.
- State S_IDLE:
  - Leaves on the first tick (modes 01/10) or the first step edge (mode 11). Mode 00 stays in S_IDLE.
  - On exit, color_idx becomes 1.
  - Mode 01/11 exit: outputs load red directly, next state S_HOLD.
  - Mode 10 exit: next state S_FADE.
- State S_HOLD:
  - Outputs equal the palette entry of color_idx.
  - Modes 01/10: the hold counter increments on each tick. When a tick arrives with the counter at HOLD_TICKS-1, the counter clears and color_idx advances.
  - Mode 01: outputs jump to the new entry in the same register update; remain in S_HOLD.
  - Mode 10: go to S_FADE.
  - Mode 11: ticks are ignored. Each step edge advances color_idx, loads the new entry directly, and clears the hold counter.
- State S_FADE:
  - On each tick, every channel moves 1 toward its target channel: +1 if below, −1 if above, unchanged if equal.
  - When all three channels equal the target, go to S_HOLD with the hold counter cleared.
  - A fade takes at most 255 ticks.
  - fading = 1 exactly while in S_FADE.
- Step edge:
  - step_q is registered every cycle.
  - Edge = step & ~step_q. Outputs reflect the advance at the clk edge following the one where the edge is detected.
  - Edges are ignored in modes 00/01/10.
  - A step edge coinciding with a tick in mode 11 produces exactly one advance.
- Mode changes take effect the cycle they are sampled:
  - To 00 from any state: all registers freeze, outputs held, step ignored.
  - Return from 00: resume the frozen state with no lost or extra tick.
  - 10→01 or 10→11 while in S_FADE: outputs load the target entry on the next cycle, fading drops, state S_HOLD, hold counter cleared.
  - 01/11→10 while in S_HOLD: no immediate effect. The next advance fades.
- Reset mid-fade or mid-hold returns all registers to their reset values asynchronously.

Decomposition:
- Package rgb_seq_pkg holds:
  - palette constants (8×24-bit table or per-channel arrays)
  - mode encodings (MODE_FREEZE=2'b00, MODE_JUMP=2'b01, MODE_FADE=2'b10, MODE_MANUAL=2'b11)
  - state encodings (S_IDLE, S_HOLD, S_FADE)
  - a next_index function implementing 7→1 wrap
- One sub-module, rgb_tick_gen: the prescaler. Parameter TICK_DIV; ports clk, rst, en, tick.
- The channel step-toward logic is replicated three times inline.

Test Plan (TICK_DIV=4, HOLD_TICKS=3):
1. Reset, sw=01, run 4 cycles → first tick sets color_idx=1, outputs (255,0,0); after 3 further ticks (12 cycles) → idx 2, outputs (255,97,0); after 7 advances total idx wraps to 1, never 0.
2. Reset, sw=10 → fading=1, R ramps 0→255 by 1 per tick with G=B=0; after 255 ticks, fading=0 and outputs (255,0,0); after 3 hold ticks, fade toward (255,97,0) completes in 97 ticks.
3. sw=10 mid-fade red→orange at G=40, switch to sw=01 → next cycle outputs (255,97,0), fading=0, hold counter 0.
4. sw=11 from reset: hold step high 10 cycles → exactly one advance (idx 1, red); toggle step 3 times → idx 4 (0,255,0); a step edge coincident with a tick → single advance.
5. sw=00 mid-fade → outputs and prescaler frozen for 50 cycles; back to sw=10 → fade resumes from the same values at the same prescaler phase.
6. Assert rst mid-fade asynchronously (between clk edges) → outputs 0, color_idx 0, fading 0 immediately; after release, idle until the next tick.

Source files
------------

// File: rtl/rgb_seq_pkg.sv
// Shared types, palette and index sequencing for the RGB sequence controller.
package rgb_seq_pkg;

  typedef enum logic [1:0] {
    MODE_FREEZE = 2'b00,
    MODE_JUMP   = 2'b01,
    MODE_FADE   = 2'b10,
    MODE_MANUAL = 2'b11
  } mode_e;

  typedef enum logic [1:0] {
    S_IDLE,
    S_HOLD,
    S_FADE
  } state_e;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } rgb_t;

  function automatic rgb_t palette(input logic [2:0] idx);
    case (idx)
      3'd1:    palette = 24'hFF0000;  // red
      3'd2:    palette = 24'hFF6100;  // orange
      3'd3:    palette = 24'hFFFF00;  // yellow
      3'd4:    palette = 24'h00FF00;  // green
      3'd5:    palette = 24'h0000FF;  // blue
      3'd6:    palette = 24'h082E54;  // pinying
      3'd7:    palette = 24'hA020F0;  // purple
      default: palette = 24'h000000;  // off
    endcase
  endfunction

  // Index 0 (off) is never re-entered: 7 wraps back to 1.
  function automatic logic [2:0] next_index(input logic [2:0] idx);
    next_index = (idx == 3'd7) ? 3'd1 : idx + 3'd1;
  endfunction

endpackage

// File: rtl/rgb_tick_gen.sv
// Prescaler producing a one-cycle tick every TICK_DIV enabled clocks; holds its phase while disabled.
module rgb_tick_gen #(
  parameter int TICK_DIV = 195313
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  output logic tick
);

  localparam int CW = $clog2(TICK_DIV);
  localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  // NOTE: combinational blocks assign every output a default first so no latch is inferred.
  always_comb begin
    cnt_d = cnt_q;
    if (en) cnt_d = (cnt_q == LAST) ? '0 : cnt_q + CW'(1);
  end

  assign tick = en && (cnt_q == LAST);

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

endmodule

// File: rtl/rgb_sequence_controller.sv
// Steps or fades the R/G/B duty words through the fixed palette; mode from sw, manual advance on step.
module rgb_sequence_controller
  import rgb_seq_pkg::*;
#(
  parameter int TICK_DIV   = 195313,
  parameter int HOLD_TICKS = 256
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] sw,
  input  logic       step,
  output logic [7:0] R_time_out,
  output logic [7:0] G_time_out,
  output logic [7:0] B_time_out,
  output logic [2:0] color_idx,
  output logic       fading
);

  localparam int HW = $clog2(HOLD_TICKS + 1);
  localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_TICKS - 1);

  mode_e         mode;
  logic          tick, step_q, step_edge;
  state_e        state_q, state_d;
  logic [2:0]    idx_q, idx_d;
  rgb_t          rgb_q, rgb_d, target, stepped;
  logic [HW-1:0] hold_q, hold_d;
  logic          fading_q, fading_d;

  assign mode      = mode_e'(sw);
  assign step_edge = step & ~step_q & (mode == MODE_MANUAL);

  rgb_tick_gen #(.TICK_DIV(TICK_DIV)) u_tick_gen (
    .clk (clk),
    .rst (rst),
    .en  (mode != MODE_FREEZE),
    .tick(tick)
  );

  // Each channel moves one count toward its target per fade tick.
  always_comb begin
    target    = palette(idx_q);
    stepped.r = (rgb_q.r < target.r) ? rgb_q.r + 8'd1 :
                (rgb_q.r > target.r) ? rgb_q.r - 8'd1 : rgb_q.r;
    stepped.g = (rgb_q.g < target.g) ? rgb_q.g + 8'd1 :
                (rgb_q.g > target.g) ? rgb_q.g - 8'd1 : rgb_q.g;
    stepped.b = (rgb_q.b < target.b) ? rgb_q.b + 8'd1 :
                (rgb_q.b > target.b) ? rgb_q.b - 8'd1 : rgb_q.b;
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    rgb_d   = rgb_q;
    hold_d  = hold_q;
    if (mode != MODE_FREEZE) begin
      case (state_q)
        S_IDLE: begin
          if ((mode == MODE_JUMP && tick) || step_edge) begin
            idx_d   = 3'd1;
            rgb_d   = palette(3'd1);
            state_d = S_HOLD;
          end else if (mode == MODE_FADE && tick) begin
            idx_d   = 3'd1;
            state_d = S_FADE;
          end
        end
        S_HOLD: begin
          if (mode == MODE_MANUAL) begin
            if (step_edge) begin
              idx_d  = next_index(idx_q);
              rgb_d  = palette(next_index(idx_q));
              hold_d = '0;
            end
          end else if (tick) begin
            if (hold_q == HOLD_LAST) begin
              hold_d = '0;
              idx_d  = next_index(idx_q);
              if (mode == MODE_JUMP) rgb_d = palette(next_index(idx_q));
              else                   state_d = S_FADE;
            end else begin
              hold_d = hold_q + HW'(1);
            end
          end
        end
        S_FADE: begin
          // Leaving fade mode mid-ramp snaps straight to the target colour.
          if (mode != MODE_FADE) begin
            rgb_d   = target;
            hold_d  = '0;
            state_d = S_HOLD;
          end else if (rgb_q == target) begin
            hold_d  = '0;
            state_d = S_HOLD;
          end else if (tick) begin
            rgb_d = stepped;
            if (stepped == target) begin
              hold_d  = '0;
              state_d = S_HOLD;
            end
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
    fading_d = (state_d == S_FADE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      idx_q    <= '0;
      rgb_q    <= '0;
      hold_q   <= '0;
      fading_q <= 1'b0;
      step_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      rgb_q    <= rgb_d;
      hold_q   <= hold_d;
      fading_q <= fading_d;
      step_q   <= step;
    end
  end

  assign R_time_out = rgb_q.r;
  assign G_time_out = rgb_q.g;
  assign B_time_out = rgb_q.b;
  assign color_idx  = idx_q;
  assign fading     = fading_q;

endmodule

// File: tb/tb_rgb_sequence_controller.sv
// Directed scenarios plus random mode/step traffic, every cycle compared against a rule-level model.
module tb_rgb_sequence_controller;

  localparam int TDIV = 4;
  localparam int HOLD = 3;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [1:0] sw = 2'b00;
  logic       step = 1'b0;
  logic [7:0] r_out, g_out, b_out;
  logic [2:0] idx_out;
  logic       fading_out;

  int checks = 0;
  int errors = 0;

  int pal_r[8] = '{0, 255, 255, 255, 0,   0,   8,  160};
  int pal_g[8] = '{0, 0,   97,  255, 255, 0,   46, 32};
  int pal_b[8] = '{0, 0,   0,   0,   0,   255, 84, 240};

  // Reference model state: colour, target index, fade flag, started flag, prescaler, hold count.
  int m_r, m_g, m_b, m_idx, m_pre, m_hold;
  bit m_fade, m_started, m_step_prev;

  rgb_sequence_controller #(.TICK_DIV(TDIV), .HOLD_TICKS(HOLD)) dut (
    .clk       (clk),
    .rst       (rst),
    .sw        (sw),
    .step      (step),
    .R_time_out(r_out),
    .G_time_out(g_out),
    .B_time_out(b_out),
    .color_idx (idx_out),
    .fading    (fading_out)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_model();
    check("R", {24'd0, r_out}, m_r);
    check("G", {24'd0, g_out}, m_g);
    check("B", {24'd0, b_out}, m_b);
    check("idx", {29'd0, idx_out}, m_idx);
    check("fading", {31'd0, fading_out}, {31'd0, m_fade});
  endtask

  task automatic model_reset();
    m_r = 0; m_g = 0; m_b = 0; m_idx = 0; m_pre = 0; m_hold = 0;
    m_fade = 0; m_started = 0; m_step_prev = 0;
  endtask

  function automatic int toward(input int cur, input int tgt);
    if (cur < tgt) return cur + 1;
    if (cur > tgt) return cur - 1;
    return cur;
  endfunction

  function automatic bit at_target();
    return m_r == pal_r[m_idx] && m_g == pal_g[m_idx] && m_b == pal_b[m_idx];
  endfunction

  task automatic load_target();
    m_r = pal_r[m_idx]; m_g = pal_g[m_idx]; m_b = pal_b[m_idx];
  endtask

  // One clock of the sequencing rules, applied to the inputs present before the edge.
  task automatic model_update();
    bit rose, tk;
    rose = step && !m_step_prev;
    m_step_prev = step;
    if (sw == 2'b00) return;
    tk = (m_pre == TDIV - 1);
    m_pre = (m_pre + 1) % TDIV;
    if (!m_started) begin
      if ((sw == 2'b01 && tk) || (sw == 2'b11 && rose)) begin
        m_started = 1; m_idx = 1; load_target();
      end else if (sw == 2'b10 && tk) begin
        m_started = 1; m_idx = 1; m_fade = 1;
      end
    end else if (m_fade) begin
      if (sw != 2'b10) begin
        load_target(); m_fade = 0; m_hold = 0;
      end else begin
        if (tk && !at_target()) begin
          m_r = toward(m_r, pal_r[m_idx]);
          m_g = toward(m_g, pal_g[m_idx]);
          m_b = toward(m_b, pal_b[m_idx]);
        end
        if (at_target()) begin m_fade = 0; m_hold = 0; end
      end
    end else if (sw == 2'b11) begin
      if (rose) begin m_idx = m_idx % 7 + 1; load_target(); m_hold = 0; end
    end else if (tk) begin
      m_hold++;
      if (m_hold == HOLD) begin
        m_hold = 0;
        m_idx = m_idx % 7 + 1;
        if (sw == 2'b01) load_target();
        else             m_fade = 1;
      end
    end
  endtask

  task automatic cycle();
    model_update();
    @(posedge clk);
    #1;
    check_model();
  endtask

  task automatic cycles(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  // Reset asserted between clock edges and checked before the next edge.
  task automatic do_reset();
    #2 rst = 1'b1;
    model_reset();
    #1;
    check_model();
    @(posedge clk);
    #1 rst = 1'b0;
  endtask

  initial begin
    // 1: auto-jump sequence and wrap
    step = 1'b0; sw = 2'b01;
    do_reset();
    cycles(3);
    check("t1_idle_idx", {29'd0, idx_out}, 0);
    cycle();
    check("t1_first_idx", {29'd0, idx_out}, 1);
    check("t1_first_R", {24'd0, r_out}, 255);
    cycles(12);
    check("t1_orange_idx", {29'd0, idx_out}, 2);
    check("t1_orange_G", {24'd0, g_out}, 97);
    cycles(60);
    check("t1_purple_idx", {29'd0, idx_out}, 7);
    cycles(12);
    check("t1_wrap_idx", {29'd0, idx_out}, 1);

    // 2: auto-fade from reset, then red to orange
    sw = 2'b10;
    do_reset();
    cycles(4);
    check("t2_fade_start", {31'd0, fading_out}, 1);
    check("t2_start_R", {24'd0, r_out}, 0);
    cycles(1020);
    check("t2_red_done", {31'd0, fading_out}, 0);
    check("t2_red_R", {24'd0, r_out}, 255);
    cycles(12);
    check("t2_orange_fading", {31'd0, fading_out}, 1);
    check("t2_orange_idx", {29'd0, idx_out}, 2);
    cycles(387);
    check("t2_orange_G96", {24'd0, g_out}, 96);
    cycle();
    check("t2_orange_done", {31'd0, fading_out}, 0);
    check("t2_orange_G", {24'd0, g_out}, 97);

    // 3: leave fade mid-ramp into jump mode
    do_reset();
    cycles(4 + 1020 + 12 + 160);
    check("t3_mid_G", {24'd0, g_out}, 40);
    sw = 2'b01;
    cycle();
    check("t3_snap_G", {24'd0, g_out}, 97);
    check("t3_snap_fading", {31'd0, fading_out}, 0);
    cycles(11);
    check("t3_next_idx", {29'd0, idx_out}, 3);

    // 4: manual stepping
    sw = 2'b11; step = 1'b0;
    do_reset();
    step = 1'b1;
    cycles(10);
    check("t4_held_idx", {29'd0, idx_out}, 1);
    for (int k = 0; k < 3; k++) begin
      step = 1'b0; cycle();
      step = 1'b1; cycle();
    end
    check("t4_toggle_idx", {29'd0, idx_out}, 4);
    check("t4_toggle_G", {24'd0, g_out}, 255);
    step = 1'b0;
    cycle();
    for (int n = 0; n < 2 * TDIV && m_pre != TDIV - 1; n++) cycle();
    step = 1'b1;
    cycle();
    check("t4_coincident_idx", {29'd0, idx_out}, 5);
    cycles(3);
    check("t4_single_adv", {29'd0, idx_out}, 5);

    // 5: freeze mid-fade and resume on the same prescaler phase
    sw = 2'b10; step = 1'b0;
    do_reset();
    cycles(206);
    check("t5_pre_R", {24'd0, r_out}, 50);
    sw = 2'b00;
    cycles(50);
    check("t5_frozen_R", {24'd0, r_out}, 50);
    check("t5_frozen_fading", {31'd0, fading_out}, 1);
    sw = 2'b10;
    cycle();
    check("t5_resume_R", {24'd0, r_out}, 50);
    cycle();
    check("t5_resume_tick_R", {24'd0, r_out}, 51);

    // 6: asynchronous reset mid-fade, then idle until the next tick
    cycles(60);
    do_reset();
    check("t6_rst_fading", {31'd0, fading_out}, 0);
    check("t6_rst_idx", {29'd0, idx_out}, 0);
    cycles(3);
    check("t6_idle_fading", {31'd0, fading_out}, 0);
    cycle();
    check("t6_tick_fading", {31'd0, fading_out}, 1);

    // Random mode and step traffic with occasional resets
    sw = 2'($urandom_range(0, 3));
    do_reset();
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 63) == 0) sw = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 3) == 0) step = ~step;
      if ($urandom_range(0, 999) == 0) do_reset();
      cycle();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
